// File: rtl/pim_sequencer_if.sv
// ---------------------------------------------------------------------------
// pim_sequencer_if
//   Host-facing command/response bundle for the PIM sequencer.
//   Command channel : cmd_valid/cmd_ready handshake carrying {cmd_a, cmd_b, cmd_op}.
//   Response channel: rsp_valid/rsp_ready handshake carrying rsp_data.
//   Modports:
//     master - host side (offers commands, consumes responses)
//     slave  - sequencer side (accepts commands, produces responses)
// ---------------------------------------------------------------------------
interface pim_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [OPW-1:0]   cmd_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pim_sequencer.sv
// ---------------------------------------------------------------------------
// pim_sequencer
//   Command-side driver for the PIM datapath (register file + ALU). Takes one
//   {a, b, op} command, loads a into register select 0 and b into register
//   select 1, presents op to the ALU, captures the result and returns it on
//   the response channel. One operation in flight at a time.
//   Ports:
//     clk              rising-edge clock
//     rst              asynchronous active-high reset
//     bus              command/response channels (pim_sequencer_if.slave)
//     o_dp_reg_select  datapath register select
//     o_dp_load_data   datapath load data
//     o_dp_load_enable datapath load strobe, one cycle per register
//     o_dp_opcode      datapath ALU opcode
//     i_dp_out         datapath ALU result (combinational from its registers)
//     o_busy           high whenever an operation is in progress
//     o_done_count     completed responses, wraps at 2^CNTW
// ---------------------------------------------------------------------------
module pim_sequencer #(
  parameter int WIDTH = 32,
  parameter int OPW   = 2,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  pim_sequencer_if.slave    bus,
  output logic              o_dp_reg_select,
  output logic [WIDTH-1:0]  o_dp_load_data,
  output logic              o_dp_load_enable,
  output logic [OPW-1:0]    o_dp_opcode,
  input  logic [WIDTH-1:0]  i_dp_out,
  output logic              o_busy,
  output logic [CNTW-1:0]   o_done_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic [CNTW-1:0]  r_done_count;

  logic             w_cmd_ready;
  logic             w_load_enable;
  logic             w_reg_select;
  logic [WIDTH-1:0] w_load_data;
  logic [OPW-1:0]   w_opcode;
  logic             w_rsp_valid;
  logic             w_busy;
  logic             w_accept;
  logic             w_complete;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and all state-decoded outputs
  always_comb begin
    w_state_next  = r_state;
    w_cmd_ready   = 1'b0;
    w_load_enable = 1'b0;
    w_reg_select  = 1'b0;
    w_load_data   = '0;
    w_opcode      = r_op;   // held from LOAD_A through RESP
    w_rsp_valid   = 1'b0;
    w_busy        = 1'b1;
    w_accept      = 1'b0;
    w_complete    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        w_opcode    = '0;
        if (bus.cmd_valid) begin
          w_accept     = 1'b1;
          w_state_next = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        w_load_enable = 1'b1;
        w_reg_select  = 1'b0;
        w_load_data   = r_a;
        w_state_next  = S_LOAD_B;
      end
      S_LOAD_B: begin
        w_load_enable = 1'b1;
        w_reg_select  = 1'b1;
        w_load_data   = r_b;
        w_state_next  = S_EXEC;
      end
      S_EXEC: begin
        // Both registers are loaded; ALU output settles this cycle.
        w_state_next = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        // Completion returns to IDLE; a command offered now is taken next cycle.
        if (bus.rsp_ready) begin
          w_complete   = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand latches, result capture and completion counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_rsp_data   <= '0;
      r_done_count <= '0;
    end else begin
      // Operands are sampled only at the accept edge.
      if (w_accept) begin
        r_a  <= bus.cmd_a;
        r_b  <= bus.cmd_b;
        r_op <= bus.cmd_op;
      end
      if (r_state == S_EXEC) begin
        r_rsp_data <= i_dp_out;
      end
      if (w_complete) begin
        r_done_count <= r_done_count + CNTW'(1);
      end
    end
  end

  assign bus.cmd_ready    = w_cmd_ready;
  assign bus.rsp_valid    = w_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign o_dp_reg_select  = w_reg_select;
  assign o_dp_load_data   = w_load_data;
  assign o_dp_load_enable = w_load_enable;
  assign o_dp_opcode      = w_opcode;
  assign o_busy           = w_busy;
  assign o_done_count     = r_done_count;

endmodule

// File: tb/tb_pim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pim_sequencer
//   Self-checking bench for pim_sequencer with a datapath stub
//   (op 0 A+B, 1 A-B, 2 A&B, 3 A|B). A second instance with CNTW=2 shares
//   the same stimulus to exercise counter wrap.
// ---------------------------------------------------------------------------
module tb_pim_sequencer;
  localparam int W  = 32;
  localparam int OW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pim_sequencer_if #(.WIDTH(W), .OPW(OW)) bus ();
  pim_sequencer_if #(.WIDTH(W), .OPW(OW)) bus2 ();

  logic          dp_sel, dp_le, dp_busy;
  logic [W-1:0]  dp_data, dp_out;
  logic [OW-1:0] dp_op;
  logic [15:0]   done_cnt;

  logic          dp_sel2, dp_le2, dp_busy2;
  logic [W-1:0]  dp_data2;
  logic [OW-1:0] dp_op2;
  logic [1:0]    done_cnt2;

  pim_sequencer #(.WIDTH(W), .OPW(OW), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .o_dp_reg_select(dp_sel), .o_dp_load_data(dp_data), .o_dp_load_enable(dp_le),
    .o_dp_opcode(dp_op), .i_dp_out(dp_out), .o_busy(dp_busy), .o_done_count(done_cnt)
  );

  pim_sequencer #(.WIDTH(W), .OPW(OW), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .o_dp_reg_select(dp_sel2), .o_dp_load_data(dp_data2), .o_dp_load_enable(dp_le2),
    .o_dp_opcode(dp_op2), .i_dp_out(dp_out), .o_busy(dp_busy2), .o_done_count(done_cnt2)
  );

  assign bus2.cmd_valid = bus.cmd_valid;
  assign bus2.cmd_a     = bus.cmd_a;
  assign bus2.cmd_b     = bus.cmd_b;
  assign bus2.cmd_op    = bus.cmd_op;
  assign bus2.rsp_ready = bus.rsp_ready;

  // Datapath stub: two registers and a combinational ALU
  logic [W-1:0] stub_r0 = '0;
  logic [W-1:0] stub_r1 = '0;
  always @(posedge clk) begin
    if (dp_le) begin
      if (dp_sel) stub_r1 <= dp_data;
      else        stub_r0 <= dp_data;
    end
  end
  always_comb begin
    case (dp_op)
      2'd0:    dp_out = stub_r0 + stub_r1;
      2'd1:    dp_out = stub_r0 - stub_r1;
      2'd2:    dp_out = stub_r0 & stub_r1;
      default: dp_out = stub_r0 | stub_r1;
    endcase
  end

  int n_vec = 0;
  int n_err = 0;
  int load_pulses = 0;
  int exp_done = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] mon_exp;

  always @(posedge clk) if (dp_le) load_pulses++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Response scoreboard: a handshake is visible at the falling edge before
  // the completing rising edge.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("rsp_data", bus.rsp_data, mon_exp);
        chk("rsp_data_cntw2", bus2.rsp_data, mon_exp);
        exp_done++;
        $display("rsp: data=%h expected=%h done=%0d", bus.rsp_data, mon_exp, exp_done);
      end
    end
  end

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [OW-1:0] op;
    logic [W-1:0]  res;
    logic [1:0]    cnt2;
  } vec_t;
  vec_t vecs[8];

  // Offer a command (called at a falling edge); returns falling edges waited.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] op,
                      input logic [W-1:0] res, output int waits);
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_valid = 1'b1;
    waits = 0;
    while (!bus.cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", {31'd0, bus.cmd_ready}, 32'd1);
    end else begin
      sb_q.push_back(res);
      $display("cmd: a=%h b=%h op=%0d expect=%h", a, b, op, res);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic scramble();
    bus.cmd_valid = 1'b0;
    bus.cmd_a = $urandom; bus.cmd_b = $urandom; bus.cmd_op = OW'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || !bus.cmd_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, (sb_q.size() == 0 && bus.cmd_ready)}, 32'd1);
  endtask

  // Full cycle-by-cycle check of one operation with rsp_ready high.
  task automatic run_vec(input int i);
    int w;
    chk("pre_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("pre_busy", {31'd0, dp_busy}, 32'd0);
    load_pulses = 0;
    send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, w);
    chk("accept_wait", w, 32'd0);
    scramble();
    @(negedge clk);  // LOAD_A
    chk("la_le", {31'd0, dp_le}, 32'd1);
    chk("la_sel", {31'd0, dp_sel}, 32'd0);
    chk("la_data", dp_data, vecs[i].a);
    chk("la_op", {30'd0, dp_op}, {30'd0, vecs[i].op});
    chk("la_ready", {31'd0, bus.cmd_ready}, 32'd0);
    chk("la_busy", {31'd0, dp_busy}, 32'd1);
    chk("la_le2", {31'd0, dp_le2}, 32'd1);
    @(negedge clk);  // LOAD_B
    chk("lb_le", {31'd0, dp_le}, 32'd1);
    chk("lb_sel", {31'd0, dp_sel}, 32'd1);
    chk("lb_data", dp_data, vecs[i].b);
    chk("lb_sel2", {31'd0, dp_sel2}, 32'd1);
    chk("lb_data2", dp_data2, vecs[i].b);
    @(negedge clk);  // EXEC
    chk("ex_le", {31'd0, dp_le}, 32'd0);
    chk("ex_sel", {31'd0, dp_sel}, 32'd0);
    chk("ex_data", dp_data, 32'd0);
    chk("ex_op", {30'd0, dp_op}, {30'd0, vecs[i].op});
    chk("ex_op2", {30'd0, dp_op2}, {30'd0, vecs[i].op});
    @(negedge clk);  // RESP
    chk("rs_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("rs_valid2", {31'd0, bus2.rsp_valid}, 32'd1);
    chk("rs_busy2", {31'd0, dp_busy2}, 32'd1);
    @(negedge clk);  // back in IDLE
    chk("id_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("id_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("id_ready2", {31'd0, bus2.cmd_ready}, 32'd1);
    chk("id_busy", {31'd0, dp_busy}, 32'd0);
    chk("done_count", {16'd0, done_cnt}, exp_done);
    chk("done_count_cntw2", {30'd0, done_cnt2}, {30'd0, vecs[i].cnt2});
    chk("load_pulses", load_pulses, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    int n;
    int d0;
    vecs[0] = '{32'd5,         32'd7,         2'd0, 32'd12,         2'd1};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1,         2'd0, 32'd0,          2'd2};
    vecs[2] = '{32'd0,         32'd1,         2'd1, 32'hFFFF_FFFF,  2'd3};
    vecs[3] = '{32'd1,         32'd1,         2'd0, 32'd2,          2'd1};
    vecs[4] = '{32'hA5A5_A5A5, 32'h0F0F_0F0F, 2'd2, 32'h0505_0505,  2'd2};
    vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'd3, 32'hFFFF_FFFF,  2'd3};
    vecs[6] = '{32'd100,       32'd58,        2'd1, 32'd42,         2'd0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 2'd0, 32'd0,          2'd1};

    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0;
    bus.rsp_ready = 1'b1;

    // Reset values
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, dp_busy}, 32'd0);
    chk("rst_le", {31'd0, dp_le}, 32'd0);
    chk("rst_sel", {31'd0, dp_sel}, 32'd0);
    chk("rst_data", dp_data, 32'd0);
    chk("rst_op", {30'd0, dp_op}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    chk("rst_done", {16'd0, done_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic operations, including add/sub wrap boundaries
    for (int i = 0; i < 3; i++) run_vec(i);

    // Response backpressure, then response completion with a command waiting
    bus.rsp_ready = 1'b0;
    d0 = exp_done;
    send(32'h10, 32'h3, 2'd1, 32'hD, w);
    scramble();
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_latency", n, 32'd3);
    for (int k = 0; k < 6; k++) begin
      chk("stall_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("stall_data", bus.rsp_data, 32'hD);
      chk("stall_ready", {31'd0, bus.cmd_ready}, 32'd0);
      chk("stall_busy", {31'd0, dp_busy}, 32'd1);
      chk("stall_done", {16'd0, done_cnt}, d0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    send(32'd2, 32'd3, 2'd0, 32'd5, w);
    chk("complete_then_accept_wait", w, 32'd1);
    scramble();
    wait_idle();
    chk("stall_done_after", {16'd0, done_cnt}, exp_done);

    // Back-to-back commands with cmd_valid held
    send(32'hF0, 32'h3C, 2'd2, 32'h30, w);
    chk("b2b_first_wait", w, 32'd0);
    @(negedge clk);
    send(32'hF0, 32'h0F, 2'd3, 32'hFF, w);
    chk("b2b_second_wait", w, 32'd4);
    scramble();
    wait_idle();
    chk("b2b_done", {16'd0, done_cnt}, exp_done);

    // Command inputs changing after acceptance are ignored
    load_pulses = 0;
    send(32'h21, 32'h02, 2'd0, 32'h23, w);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("chg_lb_sel", {31'd0, dp_sel}, 32'd1);
    bus.cmd_a = 32'hDEAD; bus.cmd_b = 32'hBEEF; bus.cmd_op = 2'd3;
    wait_idle();
    chk("chg_load_pulses", load_pulses, 32'd2);

    // Reset during LOAD_B
    send(32'h40, 32'h2, 2'd1, 32'h3E, w);
    scramble();
    @(negedge clk);
    @(negedge clk);
    chk("mid_le_before", {31'd0, dp_le}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_le", {31'd0, dp_le}, 32'd0);
    chk("mid_sel", {31'd0, dp_sel}, 32'd0);
    chk("mid_data", dp_data, 32'd0);
    chk("mid_op", {30'd0, dp_op}, 32'd0);
    chk("mid_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("mid_busy", {31'd0, dp_busy}, 32'd0);
    chk("mid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rsp_data", bus.rsp_data, 32'd0);
    chk("mid_done", {16'd0, done_cnt}, 32'd0);
    chk("mid_done2", {30'd0, done_cnt2}, 32'd0);
    sb_q.delete();
    exp_done = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Post-reset operations; CNTW=2 counter runs 1,2,3,0,1
    for (int i = 3; i < 8; i++) run_vec(i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
